// File: rtl/uart_loader_if.sv
// Memory write bus and loader status toward the RV32I core.
interface uart_loader_if #(
    parameter int ADDR_W = 12
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic              busy;

    // Loader side drives the bus.
    modport master (
        output mem_we, mem_addr, mem_wdata, cpu_reset, done, error, busy
    );

    // Core/memory side observes it.
    modport slave (
        input mem_we, mem_addr, mem_wdata, cpu_reset, done, error, busy
    );
endinterface

// File: rtl/uart_loader.sv
// UART boot loader: receives LEN_LO, LEN_HI, 4*N data bytes and an 8-bit
// wrapping checksum, writes little-endian words into core memory and
// releases the core reset once the image has been verified.
module uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 12,
    parameter int MAX_WORDS    = 2056
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ser_rx,
    uart_loader_if.master bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_LEN0,
        LD_LEN1,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic      sync1_q, sync2_q;
    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frame_err_q, frame_err_d;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
        end
    end

    // RX state register, bit timer, shift register and byte/error strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // RX next-state: mid-bit sampling after a half-bit start qualification.
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (sync2_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    ld_state_t         ld_state_q, ld_state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       word_q, word_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       len_new;

    assign len_new = {shreg_q, len_q[7:0]};

    // Loader state register and registered memory-write outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_state_q <= LD_LEN0;
            len_q      <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Loader next-state: length check, word assembly, checksum compare.
    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (frame_err_q && ld_state_q != LD_DONE && ld_state_q != LD_ERR) begin
            ld_state_d = LD_ERR;
        end else if (byte_valid_q) begin
            unique case (ld_state_q)
                LD_LEN0: begin
                    len_d      = {8'h00, shreg_q};
                    sum_d      = sum_q + shreg_q;
                    ld_state_d = LD_LEN1;
                end
                LD_LEN1: begin
                    len_d = len_new;
                    sum_d = sum_q + shreg_q;
                    if (32'(len_new) > 32'(MAX_WORDS)) begin
                        ld_state_d = LD_ERR;
                    end else if (len_new == 16'd0) begin
                        ld_state_d = LD_CSUM;
                    end else begin
                        ld_state_d = LD_DATA;
                    end
                end
                LD_DATA: begin
                    sum_d  = sum_q + shreg_q;
                    word_d = {shreg_q, word_q[23:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        mem_we_d = 1'b1;
                        addr_d   = idx_q;
                        wdata_d  = {shreg_q, word_q};
                        idx_d    = idx_q + 1'b1;
                        if (16'(idx_q) == len_q - 16'd1) begin
                            ld_state_d = LD_CSUM;
                        end
                    end
                end
                LD_CSUM: begin
                    ld_state_d = (shreg_q == sum_q) ? LD_DONE : LD_ERR;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.done      = (ld_state_q == LD_DONE);
    assign bus.error     = (ld_state_q == LD_ERR);
    assign bus.cpu_reset = (ld_state_q != LD_DONE);
    assign bus.busy      = (ld_state_q == LD_LEN1) || (ld_state_q == LD_DATA) ||
                           (ld_state_q == LD_CSUM);

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: expected writes are queued by the
// stimulus and consumed by an independent write monitor.
module tb_uart_loader;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser_rx = 1'b1;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];

    uart_loader_if #(.ADDR_W(12)) bus ();

    uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(12),
        .MAX_WORDS(2056)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ser_rx(ser_rx),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Nominal image: 2 words; checksum of these ten bytes is 0x58.
    logic [7:0] nom [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h73, 8'h10, 8'h00, 8'hC0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        ser_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_nominal();
        exp_q.push_back('{a: 12'd0, d: 32'h0000_0013});
        exp_q.push_back('{a: 12'd1, d: 32'hC000_1073});
    endtask

    task automatic send_nominal(input logic [7:0] csum);
        for (int i = 0; i < 10; i++) send_byte(nom[i], 1'b1);
        send_byte(csum, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e,
                              input logic cr, input logic b);
        chk({tag, "_done"},      32'(bus.done),      32'(d));
        chk({tag, "_error"},     32'(bus.error),     32'(e));
        chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'(cr));
        chk({tag, "_busy"},      32'(bus.busy),      32'(b));
        chk({tag, "_pending"},   32'(exp_q.size()),  32'd0);
    endtask

    // Write monitor: every mem_we pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && bus.mem_we === 1'b1) begin
            wr_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h want no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d) begin
                    bad++;
                    $display("FAIL write: got addr=%0h data=%0h want addr=%0h data=%0h",
                             bus.mem_addr, bus.mem_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", bus.mem_wdata,      32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal load, with busy observed after the first byte
        push_nominal();
        send_byte(nom[0], 1'b1);
        chk("nom_busy_mid", 32'(bus.busy), 32'd1);
        for (int i = 1; i < 10; i++) send_byte(nom[i], 1'b1);
        chk("nom_cpu_reset_pre", 32'(bus.cpu_reset), 32'd1);
        send_byte(8'h58, 1'b1);
        repeat (4) @(negedge clk);
        chk_status("nom", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nom_addr_hold",  32'(bus.mem_addr), 32'd1);
        chk("nom_wdata_hold", bus.mem_wdata,     32'hC000_1073);
        // Traffic after done is ignored
        send_byte(8'hFF, 1'b0);
        send_byte(8'h12, 1'b1);
        chk_status("post_done", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bad checksum
        do_reset();
        push_nominal();
        send_nominal(8'h5B);
        chk_status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);

        // Framing error on the third byte; later bytes ignored
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b0);
        repeat (4) @(negedge clk);
        chk_status("frame", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 3; i < 10; i++) send_byte(nom[i], 1'b1);
        send_byte(8'h58, 1'b1);
        chk_status("frame_after", 1'b0, 1'b1, 1'b1, 1'b0);

        // Oversize: 0x0809 = 2057 words
        do_reset();
        send_byte(8'h09, 1'b1);
        send_byte(8'h08, 1'b1);
        chk_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);

        // Exact capacity is accepted: 0x0808 = 2056 words
        do_reset();
        send_byte(8'h08, 1'b1);
        send_byte(8'h08, 1'b1);
        chk_status("maxlen", 1'b0, 1'b0, 1'b1, 1'b1);

        // Empty image
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        chk_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

        // One-cycle glitch: no byte taken, following load still aligned
        do_reset();
        @(negedge clk);
        ser_rx = 1'b0;
        @(negedge clk);
        ser_rx = 1'b1;
        repeat (60) @(negedge clk);
        chk_status("glitch", 1'b0, 1'b0, 1'b1, 1'b0);
        push_nominal();
        send_nominal(8'h58);
        chk_status("glitch_load", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset after 5 data bytes, then mid-frame, then a full reload
        do_reset();
        exp_q.push_back('{a: 12'd0, d: 32'h0000_0013});
        for (int i = 0; i < 7; i++) send_byte(nom[i], 1'b1);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (6) @(negedge clk);
        reset  = 1'b1;
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_mem_addr",  32'(bus.mem_addr), 32'd0);
        chk("abort_mem_wdata", bus.mem_wdata,     32'd0);
        chk_status("abort", 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_nominal();
        send_nominal(8'h58);
        chk_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
